hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble insertion, multi-cycle mul/div
// stall with watchdog, and exception flush, resolved by a fixed priority.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs_raddr,
  input  logic [4:0] id_rt_raddr,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_is_load,
  input  logic       id_we,
  input  logic [4:0] id_waddr,
  input  logic       ex_div_start,
  input  logic       ex_div_ready,
  input  logic       exc_flush,
  output logic [5:0] stall,
  output logic       flush,
  output logic       load_use,
  output logic       div_timeout
);

  typedef enum logic {IDLE, DIV_BUSY} state_e;

  localparam logic [5:0] StallNone = 6'b000000;
  localparam logic [5:0] StallDiv  = 6'b001111;
  localparam logic [5:0] StallLoad = 6'b000111;
  localparam logic [5:0] CntMax    = 6'd63;
  localparam logic [5:0] CntLimit  = 6'd40;

  state_e     state_q, state_d;
  logic       exLdValid_q, exLdValid_d;
  logic [4:0] exLdWaddr_q, exLdWaddr_d;
  logic [5:0] divCnt_q, divCnt_d;
  logic       divTimeout_q, divTimeout_d;
  logic       hit;
  logic       divStall;

  assign hit = exLdValid_q & id_valid &
               ((id_rs_used & (id_rs_raddr == exLdWaddr_q)) |
                (id_rt_used & (id_rt_raddr == exLdWaddr_q)));

  assign divStall = ((state_q == IDLE) & ex_div_start & ~ex_div_ready) |
                    ((state_q == DIV_BUSY) & ~ex_div_ready);

  // Next state plus the prioritised stall/flush table: flush beats mul/div beats load-use.
  always_comb begin
    state_d  = state_q;
    stall    = StallNone;
    flush    = 1'b0;
    load_use = 1'b0;
    case (state_q)
      IDLE:     if (ex_div_start & ~exc_flush & ~ex_div_ready) state_d = DIV_BUSY;
      DIV_BUSY: if (ex_div_ready | exc_flush) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (exc_flush) begin
      flush = 1'b1;
    end else if (divStall) begin
      stall = StallDiv;
    end else if (hit) begin
      stall    = StallLoad;
      load_use = 1'b1;
    end
  end

  always_comb begin
    divCnt_d     = divCnt_q;
    divTimeout_d = divTimeout_q;
    if ((state_q == IDLE) && (state_d == DIV_BUSY)) begin
      divCnt_d = '0;
    end else if (state_q == DIV_BUSY) begin
      if (divCnt_q != CntMax) divCnt_d = divCnt_q + 6'd1;
      if (divCnt_d == CntLimit) divTimeout_d = 1'b1;
    end
  end

  // The tracker follows the ID->EX handoff: advance, take a bubble, or hold.
  always_comb begin
    exLdValid_d = exLdValid_q;
    exLdWaddr_d = exLdWaddr_q;
    if (exc_flush) begin
      exLdValid_d = 1'b0;
    end else if (!stall[2]) begin
      exLdValid_d = id_valid & id_is_load & id_we & (id_waddr != 5'd0);
      exLdWaddr_d = id_waddr;
    end else if (!stall[3]) begin
      exLdValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      exLdValid_q  <= 1'b0;
      exLdWaddr_q  <= '0;
      divCnt_q     <= '0;
      divTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exLdValid_q  <= exLdValid_d;
      exLdWaddr_q  <= exLdWaddr_d;
      divCnt_q     <= divCnt_d;
      divTimeout_q <= divTimeout_d;
    end
  end

  assign div_timeout = divTimeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: inputs change just after each rising
// edge and outputs are compared mid-cycle against hand-computed values.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs_raddr;
  logic [4:0] id_rt_raddr;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       id_is_load;
  logic       id_we;
  logic [4:0] id_waddr;
  logic       ex_div_start;
  logic       ex_div_ready;
  logic       exc_flush;
  logic [5:0] stall;
  logic       flush;
  logic       load_use;
  logic       div_timeout;

  int checkCount = 0;
  int errorCount = 0;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs_raddr  (id_rs_raddr),
    .id_rt_raddr  (id_rt_raddr),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_is_load   (id_is_load),
    .id_we        (id_we),
    .id_waddr     (id_waddr),
    .ex_div_start (ex_div_start),
    .ex_div_ready (ex_div_ready),
    .exc_flush    (exc_flush),
    .stall        (stall),
    .flush        (flush),
    .load_use     (load_use),
    .div_timeout  (div_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic rsUsed,
                               input logic [4:0] rt, input logic rtUsed, input logic isLoad,
                               input logic we, input logic [4:0] waddr, input logic divStart,
                               input logic divReady, input logic excFlush);
    id_valid     = valid;
    id_rs_raddr  = rs;
    id_rs_used   = rsUsed;
    id_rt_raddr  = rt;
    id_rt_used   = rtUsed;
    id_is_load   = isLoad;
    id_we        = we;
    id_waddr     = waddr;
    ex_div_start = divStart;
    ex_div_ready = divReady;
    exc_flush    = excFlush;
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    tick();
    tick();
    checkOutput("reset stall", 32'(stall), 32'h00);
    checkOutput("reset flush", 32'(flush), 32'h0);
    checkOutput("reset load_use", 32'(load_use), 32'h0);
    checkOutput("reset div_timeout", 32'(div_timeout), 32'h0);
    rst = 1'b0;

    // lw $8, then a reader of $8 through rs
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
    checkOutput("lw issue stall", 32'(stall), 32'h00);
    tick();
    applyStimulus(1, 8, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    checkOutput("lu rs stall", 32'(stall), 32'h07);
    checkOutput("lu rs load_use", 32'(load_use), 32'h1);
    tick();
    checkOutput("lu bubble over stall", 32'(stall), 32'h00);
    checkOutput("lu bubble over load_use", 32'(load_use), 32'h0);
    tick();

    // rt path, and rt not used
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0);
    tick();
    applyStimulus(1, 9, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("unused regs stall", 32'(stall), 32'h00);
    applyStimulus(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("lu rt stall", 32'(stall), 32'h07);
    tick();
    idleInputs();
    tick();

    // no false hazards: $0 load, non-load writer, invalid load
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load r0 stall", 32'(stall), 32'h00);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    tick();
    applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu writer stall", 32'(stall), 32'h00);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
    tick();
    applyStimulus(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("invalid load stall", 32'(stall), 32'h00);
    tick();

    // divide completing 32 cycles after start
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("div start stall", 32'(stall), 32'h0F);
    tick();
    for (int i = 1; i <= 31; i++) begin
      idleInputs();
      checkOutput("div busy stall", 32'(stall), 32'h0F);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("div ready stall", 32'(stall), 32'h00);
    tick();
    idleInputs();
    checkOutput("div idle stall", 32'(stall), 32'h00);
    checkOutput("div no timeout", 32'(div_timeout), 32'h0);
    tick();

    // load-use masked by divide, re-evaluated on ready
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 10, 0, 0, 0);
    tick();
    applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("masked lu stall", 32'(stall), 32'h0F);
    checkOutput("masked lu load_use", 32'(load_use), 32'h0);
    tick();
    applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("masked lu busy stall", 32'(stall), 32'h0F);
    tick();
    applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("lu after div stall", 32'(stall), 32'h07);
    checkOutput("lu after div load_use", 32'(load_use), 32'h1);
    tick();
    applyStimulus(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lu after div done stall", 32'(stall), 32'h00);
    tick();

    // flush beats divide and pending hit
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 11, 0, 0, 0);
    tick();
    applyStimulus(1, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("pre flush stall", 32'(stall), 32'h0F);
    tick();
    applyStimulus(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("flush flush", 32'(flush), 32'h1);
    checkOutput("flush stall", 32'(stall), 32'h00);
    checkOutput("flush load_use", 32'(load_use), 32'h0);
    tick();
    applyStimulus(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post flush stall", 32'(stall), 32'h00);
    checkOutput("post flush flush", 32'(flush), 32'h0);
    tick();

    // watchdog
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    for (int i = 1; i <= 45; i++) begin
      idleInputs();
      checkOutput("wd timeout", 32'(div_timeout), (i >= 41) ? 32'h1 : 32'h0);
      checkOutput("wd stall", 32'(stall), 32'h0F);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("wd ready stall", 32'(stall), 32'h00);
    tick();
    idleInputs();
    checkOutput("wd sticky", 32'(div_timeout), 32'h1);
    checkOutput("wd idle stall", 32'(stall), 32'h00);

    // reset in the middle of a divide
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    idleInputs();
    checkOutput("rst pre stall", 32'(stall), 32'h0F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idleInputs();
    checkOutput("rst mid stall", 32'(stall), 32'h00);
    checkOutput("rst mid flush", 32'(flush), 32'h0);
    checkOutput("rst mid load_use", 32'(load_use), 32'h0);
    checkOutput("rst mid timeout", 32'(div_timeout), 32'h0);
    tick();
    checkOutput("rst after stall", 32'(stall), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
